clock_div_multi: RTL and testbench

- Parametrised multi-channel clock divider driven from clock32. Generalises the fixed /4, /8, /16 divider chain.
- Each channel has its own half-period register, reprogrammable at runtime. New ratios are applied glitch-free at the end of a period.
- Provides per-channel rising-edge tick pulses, a global count enable, and a synchronous phase-align command. Feeds the PCIe layer blocks that need slower derived clocks or enables.

---
 rtl/clock_div_multi.sv | 123 ++++++++++++
 tb/tb_clock_div_multi.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider running on clock32.
// Each channel toggles clk_out after eff half-period edges; new ratios take effect at a 1->0 toggle.
module clock_div_multi #(
    parameter int                      NUM_CH    = 3,
    parameter int                      DIV_W     = 8,
    parameter logic [NUM_CH*DIV_W-1:0] RESET_DIV = {8'd8, 8'd4, 8'd2}
) (
    input  logic                    clock32,
    input  logic                    reset_L,
    input  logic                    enable,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    cfg_load,
    input  logic                    align,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       cfg_pending
);

    localparam logic [DIV_W-1:0] ONE_C = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [DIV_W-1:0]  hp_q     [NUM_CH];
    logic [DIV_W-1:0]  hp_d     [NUM_CH];
    logic [DIV_W-1:0]  shadow_q [NUM_CH];
    logic [DIV_W-1:0]  shadow_d [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q;
    logic [NUM_CH-1:0] clk_out_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;

    // A programmed half-period of zero behaves as one, i.e. divide-by-2.
    function automatic logic [DIV_W-1:0] eff_of(input logic [DIV_W-1:0] hp);
        logic [DIV_W-1:0] eff;
        if (hp == {DIV_W{1'b0}}) begin
            eff = ONE_C;
        end else begin
            eff = hp;
        end
        return eff;
    endfunction

    // Per-channel next-state: align, counting/toggling, ratio hand-over and shadow capture.
    always_comb begin
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        shadow_d  = shadow_q;
        clk_out_d = clk_out_q;
        tick_d    = {NUM_CH{1'b0}};
        pend_d    = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (align) begin
                cnt_d[i]     = {DIV_W{1'b0}};
                clk_out_d[i] = 1'b0;
                if (cfg_load) begin
                    hp_d[i]     = div_cfg[i*DIV_W +: DIV_W];
                    shadow_d[i] = div_cfg[i*DIV_W +: DIV_W];
                    pend_d[i]   = 1'b0;
                end else if (pend_q[i]) begin
                    hp_d[i]   = shadow_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    hp_d[i] = hp_q[i];
                end
            end else begin
                if (enable) begin
                    if (cnt_q[i] == eff_of(hp_q[i]) - ONE_C) begin
                        cnt_d[i]     = {DIV_W{1'b0}};
                        clk_out_d[i] = ~clk_out_q[i];
                        if (!clk_out_q[i]) begin
                            tick_d[i] = 1'b1;
                        end else if (pend_q[i]) begin
                            // Swap ratio only at the falling edge so the new low phase is whole.
                            hp_d[i]   = shadow_q[i];
                            pend_d[i] = 1'b0;
                        end else begin
                            hp_d[i] = hp_q[i];
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE_C;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
                // A fresh load always leaves the channel pending, even on a hand-over edge.
                if (cfg_load) begin
                    shadow_d[i] = div_cfg[i*DIV_W +: DIV_W];
                    pend_d[i]   = 1'b1;
                end else begin
                    shadow_d[i] = shadow_q[i];
                end
            end
        end
    end

    // State registers with asynchronous active-low reset to the power-on ratios.
    always_ff @(posedge clock32 or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= {DIV_W{1'b0}};
                hp_q[i]     <= RESET_DIV[i*DIV_W +: DIV_W];
                shadow_q[i] <= RESET_DIV[i*DIV_W +: DIV_W];
            end
            clk_out_q <= {NUM_CH{1'b0}};
            tick_q    <= {NUM_CH{1'b0}};
            pend_q    <= {NUM_CH{1'b0}};
        end else begin
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            shadow_q  <= shadow_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign cfg_pending = pend_q;

endmodule

// File: tb/tb_clock_div_multi.sv
// Bench for clock_div_multi: directed scenarios plus random traffic, all checked
// against a phase-countdown model of each channel.
module tb_clock_div_multi;

    localparam logic [23:0] RST_DIV = {8'd8, 8'd4, 8'd2};

    logic        clock32;
    logic        reset_L;
    logic        enable;
    logic [23:0] div_cfg;
    logic        cfg_load;
    logic        align;
    logic [2:0]  clk_out;
    logic [2:0]  tick;
    logic [2:0]  cfg_pending;

    clock_div_multi #(.NUM_CH(3), .DIV_W(8), .RESET_DIV(RST_DIV)) dut (
        .clock32    (clock32),
        .reset_L    (reset_L),
        .enable     (enable),
        .div_cfg    (div_cfg),
        .cfg_load   (cfg_load),
        .align      (align),
        .clk_out    (clk_out),
        .tick       (tick),
        .cfg_pending(cfg_pending)
    );

    initial clock32 = 1'b0;
    always #5 clock32 = ~clock32;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: level, edges left in the current phase, active and shadow ratio.
    int m_clk [3];
    int m_rem [3];
    int m_hp  [3];
    int m_sh  [3];
    int m_pend[3];
    int m_tick[3];

    // Bench-side measurement of the DUT waveform.
    int cyc = 0;
    int mark_cyc = 0;
    int prev_clk[3];
    int last_rise[3];
    int last_fall[3];
    int have_rise[3];
    int have_fall[3];
    int per_m[3];
    int hi_m[3];
    int lo_m[3];
    int first_rise[3];
    int rise_cnt[3];
    int min_ph[3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_clk[i]  = 0;
            m_hp[i]   = int'(RST_DIV[8*i +: 8]);
            m_sh[i]   = m_hp[i];
            m_pend[i] = 0;
            m_tick[i] = 0;
            m_rem[i]  = eff(m_hp[i]);
        end
    endtask

    task automatic model_edge();
        int c;
        int old_sh;
        int old_pend;
        if (!reset_L) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            c = int'(div_cfg[8*i +: 8]);
            m_tick[i] = 0;
            if (align) begin
                m_clk[i] = 0;
                if (cfg_load) begin
                    m_hp[i] = c; m_sh[i] = c; m_pend[i] = 0;
                end else if (m_pend[i] != 0) begin
                    m_hp[i] = m_sh[i]; m_pend[i] = 0;
                end
                m_rem[i] = eff(m_hp[i]);
            end else begin
                old_sh   = m_sh[i];
                old_pend = m_pend[i];
                if (cfg_load) begin
                    m_sh[i] = c; m_pend[i] = 1;
                end
                if (enable) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        if (m_clk[i] == 0) begin
                            m_clk[i] = 1; m_tick[i] = 1;
                        end else begin
                            m_clk[i] = 0;
                            if (old_pend != 0) begin
                                m_hp[i] = old_sh;
                                if (!cfg_load) m_pend[i] = 0;
                            end
                        end
                        m_rem[i] = eff(m_hp[i]);
                    end
                end
            end
        end
    endtask

    function automatic logic [2:0] pack3(input int v0, input int v1, input int v2);
        return {v2 != 0, v1 != 0, v0 != 0};
    endfunction

    task automatic mark();
        mark_cyc = cyc;
        for (int i = 0; i < 3; i++) begin
            prev_clk[i] = int'(clk_out[i]);
            have_rise[i] = 0; have_fall[i] = 0;
            per_m[i] = -1; hi_m[i] = -1; lo_m[i] = -1;
            first_rise[i] = -1; rise_cnt[i] = 0; min_ph[i] = 100000;
        end
    endtask

    task automatic step();
        @(posedge clock32);
        model_edge();
        #1;
        cyc++;
        check_val("clk_out", 32'(clk_out), 32'(pack3(m_clk[0], m_clk[1], m_clk[2])));
        check_val("tick", 32'(tick), 32'(pack3(m_tick[0], m_tick[1], m_tick[2])));
        check_val("cfg_pending", 32'(cfg_pending), 32'(pack3(m_pend[0], m_pend[1], m_pend[2])));
        for (int i = 0; i < 3; i++) begin
            if (clk_out[i] && prev_clk[i] == 0) begin
                if (have_rise[i] != 0) per_m[i] = cyc - last_rise[i];
                if (have_fall[i] != 0) begin
                    lo_m[i] = cyc - last_fall[i];
                    if (lo_m[i] < min_ph[i]) min_ph[i] = lo_m[i];
                end
                if (first_rise[i] < 0) first_rise[i] = cyc - mark_cyc;
                last_rise[i] = cyc; have_rise[i] = 1; rise_cnt[i]++;
            end else if (!clk_out[i] && prev_clk[i] != 0) begin
                if (have_rise[i] != 0) begin
                    hi_m[i] = cyc - last_rise[i];
                    if (hi_m[i] < min_ph[i]) min_ph[i] = hi_m[i];
                end
                last_fall[i] = cyc; have_fall[i] = 1;
            end
            prev_clk[i] = int'(clk_out[i]);
        end
    endtask

    task automatic load_align(input logic [23:0] cfg, input logic with_load);
        div_cfg  = cfg;
        cfg_load = with_load;
        align    = 1'b1;
        step();
        cfg_load = 1'b0;
        align    = 1'b0;
    endtask

    initial begin
        logic [2:0] snap;
        int         rc;
        int         guard;
        int         n;

        reset_L  = 1'b0;
        enable   = 1'b0;
        cfg_load = 1'b0;
        align    = 1'b0;
        div_cfg  = RST_DIV;
        model_reset();
        mark();
        #12;
        check_val("rst_clk_out", 32'(clk_out), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        check_val("rst_pending", 32'(cfg_pending), 32'd0);

        // Defaults after reset release.
        reset_L = 1'b1;
        enable  = 1'b1;
        mark();
        repeat (64) step();
        for (int i = 0; i < 3; i++) begin
            n = eff(int'(RST_DIV[8*i +: 8]));
            check_val("def_first_rise", 32'(first_rise[i]), 32'(n));
            check_val("def_period", 32'(per_m[i]), 32'(2 * n));
            check_val("def_high", 32'(hi_m[i]), 32'(n));
            check_val("def_low", 32'(lo_m[i]), 32'(n));
            check_val("def_ticks", 32'(rise_cnt[i]), 32'((64 - n) / (2 * n) + 1));
        end

        // Runtime reconfig of ch0 to 5 during a high phase.
        mark();
        guard = 0;
        while (!clk_out[0] && guard < 10) begin
            step();
            guard++;
        end
        check_val("reconf_wait_high", 32'(clk_out[0]), 32'd1);
        div_cfg  = {8'd8, 8'd4, 8'd5};
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        check_val("reconf_pending_set", 32'(cfg_pending[0]), 32'd1);
        step();
        check_val("reconf_old_high", 32'(hi_m[0]), 32'd2);
        check_val("reconf_pending_clr", 32'(cfg_pending[0]), 32'd0);
        repeat (30) step();
        check_val("reconf_high5", 32'(hi_m[0]), 32'd5);
        check_val("reconf_low5", 32'(lo_m[0]), 32'd5);
        check_val("reconf_min_phase", 32'(min_ph[0] >= 2), 32'd1);

        // Zero and maximum half-periods applied via load+align.
        load_align({8'd255, 8'd0, 8'd5}, 1'b1);
        check_val("zm_pending", 32'(cfg_pending), 32'd0);
        mark();
        repeat (800) step();
        check_val("zm_ch1_high", 32'(hi_m[1]), 32'd1);
        check_val("zm_ch1_low", 32'(lo_m[1]), 32'd1);
        check_val("zm_ch2_first", 32'(first_rise[2]), 32'd255);
        check_val("zm_ch2_period", 32'(per_m[2]), 32'd510);

        // Enable hold of 7 cycles in ch2's low phase.
        load_align(RST_DIV, 1'b1);
        mark();
        repeat (20) step();
        snap   = clk_out;
        enable = 1'b0;
        repeat (7) begin
            step();
            check_val("hold_tick", 32'(tick), 32'd0);
            check_val("hold_clk", 32'(clk_out), 32'(snap));
        end
        enable = 1'b1;
        rc     = rise_cnt[2];
        guard  = 0;
        while (rise_cnt[2] == rc && guard < 40) begin
            step();
            guard++;
        end
        check_val("hold_period", 32'(per_m[2]), 32'd23);

        // Align at an arbitrary phase.
        repeat ($urandom_range(3, 40)) step();
        load_align(div_cfg, 1'b0);
        check_val("align_clk_low", 32'(clk_out), 32'd0);
        mark();
        repeat (10) step();
        check_val("align_rise0", 32'(first_rise[0]), 32'd2);
        check_val("align_rise1", 32'(first_rise[1]), 32'd4);
        check_val("align_rise2", 32'(first_rise[2]), 32'd8);

        // Align together with cfg_load.
        load_align({8'd3, 8'd6, 8'd1}, 1'b1);
        check_val("alnld_pending", 32'(cfg_pending), 32'd0);
        mark();
        repeat (40) step();
        check_val("alnld_per0", 32'(per_m[0]), 32'd2);
        check_val("alnld_per1", 32'(per_m[1]), 32'd12);
        check_val("alnld_per2", 32'(per_m[2]), 32'd6);

        // Program ch0=7, then async reset between edges.
        load_align(RST_DIV, 1'b1);
        div_cfg  = {8'd8, 8'd4, 8'd7};
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        guard = 0;
        while (cfg_pending[0] && guard < 20) begin
            step();
            guard++;
        end
        check_val("rst7_applied", 32'(cfg_pending[0]), 32'd0);
        mark();
        repeat (40) step();
        check_val("rst7_period", 32'(per_m[0]), 32'd14);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_val("arst_clk_out", 32'(clk_out), 32'd0);
        check_val("arst_tick", 32'(tick), 32'd0);
        check_val("arst_pending", 32'(cfg_pending), 32'd0);
        @(posedge clock32);
        #1;
        reset_L = 1'b1;
        mark();
        repeat (20) step();
        check_val("arst_first0", 32'(first_rise[0]), 32'd2);
        check_val("arst_period0", 32'(per_m[0]), 32'd4);

        // Random traffic against the model.
        repeat (1500) begin
            enable   = ($urandom_range(0, 9) < 8);
            cfg_load = ($urandom_range(0, 19) == 0);
            align    = ($urandom_range(0, 49) == 0);
            div_cfg  = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
            step();
        end
        cfg_load = 1'b0;
        align    = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
